spicart: RTL and testbench

- SPI slave bridge that lets an external host read and write the cartridge bus.
- Sits between the host SPI pins and the cart_iface bus controller, which is a peer block.
- Decodes a 2-byte header (R/W flag plus 15-bit address), then streams data bytes with address auto-increment.
- Issues single-cycle rd/wr requests to cart_iface and obeys its busy handshake.

---
 rtl/spicart_pkg.sv | 22 ++
 rtl/spicart_spi_slave_phy.sv | 92 +++++++++
 rtl/spicart.sv | 210 +++++++++++++++++++++
 tb/tb_spicart.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spicart_pkg.sv
// Shared types and constants for the spicart SPI-to-cartridge-bus bridge.
package spicart_pkg;

  localparam int         RW_FLAG_BIT = 7;
  localparam int         ADDR_W      = 15;
  localparam logic [7:0] DUMMY_BYTE  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_RD_DUMMY,
    ST_RD_DATA,
    ST_WR_DATA
  } state_t;

  // Cartridge address auto-increment; rolls over from 0x7FFF to 0x0000.
  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/spicart_spi_slave_phy.sv
// SPI mode-0 slave bit engine: pin synchronisers, SCK edge detect,
// rx/tx shift registers and an end-of-byte strobe.
module spi_slave_phy #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  input  logic       load_tx,
  input  logic [7:0] tx_data,
  output logic       spi_miso,
  output logic       cs_level,
  output logic       cs_rise,
  output logic       byte_done,
  output logic [7:0] rx_byte
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   cs_d;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx;
  logic [7:0]             tx;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   sck_rise;
  logic                   sck_fall;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_level = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_level & ~cs_d;
  assign rx_byte  = rx;
  assign spi_miso = tx[7] & cs_level;

  // Bring the asynchronous SPI pins into clk and keep one-cycle history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sck_sync[0]  <= spi_sck;
      cs_sync[0]   <= spi_cs;
      mosi_sync[0] <= spi_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sync[i]  <= sck_sync[i-1];
        cs_sync[i]   <= cs_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
      end
      sck_d <= sck_s;
      cs_d  <= cs_level;
    end
  end

  // Shift engine. The fall that follows the 8th rise (bit_cnt wrapped to 0) is the byte
  // boundary and does not shift, so a byte loaded after byte_done keeps its MSB on MISO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx        <= '0;
      tx        <= '0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (!cs_level) begin
        rx      <= '0;
        bit_cnt <= '0;
      end else if (sck_rise) begin
        rx      <= {rx[6:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
        end
      end
      if (load_tx) begin
        tx <= tx_data;
      end else if (cs_level && sck_fall && (bit_cnt != 3'd0)) begin
        tx <= {tx[6:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/spicart.sv
// SPI slave bridge giving an external host read/write access to the cartridge bus.
//
//   state        | meaning
//   ST_IDLE      | chip select low, waiting for a CS rise
//   ST_HDR_HI    | receiving R/W flag and addr[14:8]
//   ST_HDR_LO    | receiving addr[7:0]; read issues the first rd here
//   ST_RD_DUMMY  | turnaround byte, MISO shifts 0xFF
//   ST_RD_DATA   | streaming prefetched read bytes, one rd per byte
//   ST_WR_DATA   | each received byte becomes one wr
module spicart
  import spicart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic        spi_sck,
  input  logic        spi_cs,
  output logic [7:0]  cart_dout,
  input  logic [7:0]  cart_din,
  output logic [15:0] cart_a,
  output logic        cart_wr,
  output logic        cart_rd,
  input  logic        cart_busy
);

  logic              cs_level;
  logic              cs_rise;
  logic              byte_done;
  logic [7:0]        rx_byte;
  logic              load_tx;
  logic [7:0]        tx_data;

  state_t            state;
  logic              wr_mode;
  logic [ADDR_W-1:0] addr;

  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_data;

  logic              pend_valid;
  logic              pend_wr;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0]        pend_data;

  logic              busy_d;
  logic              rd_wait;
  logic              rd_valid;
  logic [7:0]        rd_data;

  logic              rd_phase;
  logic              rd_consume;
  logic              busy_fall;
  logic              bus_free;

  assign rd_phase   = (state == ST_RD_DUMMY) || (state == ST_RD_DATA);
  assign rd_consume = rd_phase && byte_done && cs_level;
  assign busy_fall  = busy_d && !cart_busy;
  // A pulse launched last clk is not yet reflected in cart_busy.
  assign bus_free   = !cart_busy && !cart_rd && !cart_wr;

  spi_slave_phy #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_phy (
    .clk       (clk),
    .rst       (rst),
    .spi_sck   (spi_sck),
    .spi_cs    (spi_cs),
    .spi_mosi  (spi_mosi),
    .load_tx   (load_tx),
    .tx_data   (tx_data),
    .spi_miso  (spi_miso),
    .cs_level  (cs_level),
    .cs_rise   (cs_rise),
    .byte_done (byte_done),
    .rx_byte   (rx_byte)
  );

  // Transaction FSM: header decode, address tracking, request and tx-load generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wr_mode  <= 1'b0;
      addr     <= '0;
      req_rd   <= 1'b0;
      req_wr   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
      load_tx  <= 1'b0;
      tx_data  <= '0;
    end else begin
      req_rd  <= 1'b0;
      req_wr  <= 1'b0;
      load_tx <= 1'b0;
      if (!cs_level) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_rise) state <= ST_HDR_HI;
          end
          ST_HDR_HI: begin
            if (byte_done) begin
              wr_mode     <= rx_byte[RW_FLAG_BIT];
              addr[14:8]  <= rx_byte[6:0];
              state       <= ST_HDR_LO;
            end
          end
          ST_HDR_LO: begin
            if (byte_done) begin
              addr[7:0] <= rx_byte;
              if (wr_mode) begin
                state <= ST_WR_DATA;
              end else begin
                req_rd   <= 1'b1;
                req_addr <= {addr[14:8], rx_byte};
                load_tx  <= 1'b1;
                tx_data  <= DUMMY_BYTE;
                state    <= ST_RD_DUMMY;
              end
            end
          end
          ST_RD_DUMMY, ST_RD_DATA: begin
            if (byte_done) begin
              load_tx  <= 1'b1;
              tx_data  <= rd_valid ? rd_data : DUMMY_BYTE;
              addr     <= addr_next(addr);
              req_rd   <= 1'b1;
              req_addr <= addr_next(addr);
              state    <= ST_RD_DATA;
            end
          end
          ST_WR_DATA: begin
            if (byte_done) begin
              req_wr   <= 1'b1;
              req_addr <= addr;
              req_data <= rx_byte;
              addr     <= addr_next(addr);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Read-data capture on busy fall; data arriving outside a read stream is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_d   <= 1'b0;
      rd_wait  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      busy_d <= cart_busy;
      if (cart_rd) begin
        rd_wait <= 1'b1;
      end else if (busy_fall) begin
        rd_wait <= 1'b0;
      end
      if (rd_wait && busy_fall && rd_phase) begin
        rd_data  <= cart_din;
        rd_valid <= 1'b1;
      end else if (rd_consume || !rd_phase) begin
        rd_valid <= 1'b0;
      end
    end
  end

  // Bus request issue with a one-deep pending slot; a newer request overwrites the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cart_rd    <= 1'b0;
      cart_wr    <= 1'b0;
      cart_a     <= '0;
      cart_dout  <= '0;
      pend_valid <= 1'b0;
      pend_wr    <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      cart_rd <= 1'b0;
      cart_wr <= 1'b0;
      if (req_rd || req_wr) begin
        if (bus_free && !pend_valid) begin
          cart_rd <= req_rd;
          cart_wr <= req_wr;
          cart_a  <= {1'b0, req_addr};
          if (req_wr) cart_dout <= req_data;
        end else begin
          pend_valid <= 1'b1;
          pend_wr    <= req_wr;
          pend_addr  <= req_addr;
          pend_data  <= req_data;
        end
      end else if (pend_valid && bus_free) begin
        cart_rd    <= !pend_wr;
        cart_wr    <= pend_wr;
        cart_a     <= {1'b0, pend_addr};
        if (pend_wr) cart_dout <= pend_data;
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spicart.sv
// Bench for spicart: behavioural cart_iface, SPI host tasks and a transaction-level model.
module tb_spicart;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_sck = 1'b0;
  logic        spi_cs = 1'b0;
  logic [7:0]  cart_dout;
  logic [7:0]  cart_din = 8'h00;
  logic [15:0] cart_a;
  logic        cart_wr;
  logic        cart_rd;
  logic        cart_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spicart #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .spi_sck   (spi_sck),
    .spi_cs    (spi_cs),
    .cart_dout (cart_dout),
    .cart_din  (cart_din),
    .cart_a    (cart_a),
    .cart_wr   (cart_wr),
    .cart_rd   (cart_rd),
    .cart_busy (cart_busy)
  );

  // cart_iface model: busy from the clk after a request for 2..5 clk, read data = a[7:0].
  int          cyc = 0;
  int          lat_cnt = 0;
  int          force_until = 0;
  int          viol = 0;
  logic [15:0] op_addr = '0;
  logic        op_rd = 1'b0;
  logic [15:0] rd_log[$];
  logic [15:0] wr_a_log[$];
  logic [7:0]  wr_d_log[$];
  int          wr_cyc_log[$];

  assign cart_busy = (lat_cnt != 0) || (cyc < force_until);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ((cart_rd || cart_wr) && cart_busy) viol <= viol + 1;
    if (cart_rd) rd_log.push_back(cart_a);
    if (cart_wr) begin
      wr_a_log.push_back(cart_a);
      wr_d_log.push_back(cart_dout);
      wr_cyc_log.push_back(cyc);
    end
    if (cart_rd || cart_wr) begin
      lat_cnt <= $urandom_range(5, 2);
      op_addr <= cart_a;
      op_rd   <= cart_rd;
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1 && op_rd) cart_din <= op_addr[7:0];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [7:0] tx_bytes[$];
  logic [7:0] miso_bytes[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic m);
    spi_sck  = 1'b0;
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    m = spi_miso;
    spi_sck = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] m);
    logic mb;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], mb);
      m[i] = mb;
    end
  endtask

  task automatic cs_start();
    miso_bytes.delete();
    spi_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    spi_cs = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic run_txn();
    logic [7:0] m;
    cs_start();
    foreach (tx_bytes[i]) begin
      send_byte(tx_bytes[i], m);
      miso_bytes.push_back(m);
    end
    cs_end();
  endtask

  // Transaction model: header gives direction and 15-bit start address; every data byte
  // advances the address mod 2^15. Reads prefetch one ahead, so a read of n bytes issues
  // n+1 rd requests and returns FF followed by the bytes of addresses a, a+1, ...
  task automatic check_txn(input string tag, input int rd_base, input int wr_base);
    int a;
    int n;
    int nrd;
    int nwr;
    a   = {tx_bytes[0][6:0], tx_bytes[1]};
    n   = tx_bytes.size() - 2;
    nrd = rd_log.size() - rd_base;
    nwr = wr_a_log.size() - wr_base;
    if (tx_bytes[0][7]) begin
      chk({tag, ".wr_count"}, nwr, n);
      chk({tag, ".rd_count"}, nrd, 0);
      for (int k = 0; k < n; k++) begin
        if (k < nwr) begin
          chk({tag, ".wr_addr"}, wr_a_log[wr_base+k], (a + k) % 32768);
          chk({tag, ".wr_data"}, wr_d_log[wr_base+k], tx_bytes[k+2]);
        end
      end
    end else begin
      chk({tag, ".rd_count"}, nrd, n + 1);
      chk({tag, ".wr_count"}, nwr, 0);
      for (int k = 0; k <= n; k++) begin
        if (k < nrd) chk({tag, ".rd_addr"}, rd_log[rd_base+k], (a + k) % 32768);
      end
      for (int k = 0; k < n; k++) begin
        chk({tag, ".miso"}, miso_bytes[k+2], (k == 0) ? 32'hFF : ((a + k - 1) % 256));
      end
    end
  endtask

  initial begin
    int rb;
    int wb;
    logic mb;
    logic [7:0] m;

    // reset state
    repeat (4) @(negedge clk);
    chk("reset_outputs", {spi_miso, cart_wr, cart_rd, cart_dout, cart_a}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_outputs", {spi_miso, cart_wr, cart_rd}, 0);

    // directed read at 0x1234
    rb = rd_log.size(); wb = wr_a_log.size();
    tx_bytes.delete();
    tx_bytes.push_back(8'h12); tx_bytes.push_back(8'h34);
    tx_bytes.push_back(8'h00); tx_bytes.push_back(8'h00);
    tx_bytes.push_back(8'h00); tx_bytes.push_back(8'h00);
    run_txn();
    check_txn("read1234", rb, wb);

    // directed write at 0x0000
    rb = rd_log.size(); wb = wr_a_log.size();
    tx_bytes.delete();
    tx_bytes.push_back(8'h80); tx_bytes.push_back(8'h00);
    tx_bytes.push_back(8'hA0); tx_bytes.push_back(8'hA1);
    tx_bytes.push_back(8'hA2); tx_bytes.push_back(8'hA3);
    run_txn();
    check_txn("write0000", rb, wb);

    // write wrapping 0x7FFF -> 0x0000
    rb = rd_log.size(); wb = wr_a_log.size();
    tx_bytes.delete();
    tx_bytes.push_back(8'hFF); tx_bytes.push_back(8'hFF);
    tx_bytes.push_back(8'h3C); tx_bytes.push_back(8'hC3);
    run_txn();
    check_txn("write_wrap", rb, wb);

    // read wrapping 0x7FFE -> 0x0001
    rb = rd_log.size(); wb = wr_a_log.size();
    tx_bytes.delete();
    tx_bytes.push_back(8'h7F); tx_bytes.push_back(8'hFE);
    tx_bytes.push_back(8'h00); tx_bytes.push_back(8'h00);
    tx_bytes.push_back(8'h00); tx_bytes.push_back(8'h00);
    run_txn();
    check_txn("read_wrap", rb, wb);

    // abort after 4 bits of a data byte
    rb = rd_log.size(); wb = wr_a_log.size();
    cs_start();
    send_byte(8'h80, m);
    send_byte(8'h05, m);
    for (int i = 7; i >= 4; i--) send_bit(i[0], mb);
    cs_end();
    chk("abort.wr_count", wr_a_log.size() - wb, 0);
    chk("abort.rd_count", rd_log.size() - rb, 0);
    rb = rd_log.size(); wb = wr_a_log.size();
    tx_bytes.delete();
    tx_bytes.push_back(8'h81); tx_bytes.push_back(8'h22);
    tx_bytes.push_back(8'h5A);
    run_txn();
    check_txn("after_abort", rb, wb);

    // busy stretched across the second write's byte end
    rb = rd_log.size(); wb = wr_a_log.size();
    tx_bytes.delete();
    tx_bytes.push_back(8'h80); tx_bytes.push_back(8'h10);
    tx_bytes.push_back(8'h5A); tx_bytes.push_back(8'hC3);
    cs_start();
    send_byte(8'h80, m);
    send_byte(8'h10, m);
    send_byte(8'h5A, m);
    for (int i = 7; i >= 1; i--) send_bit(tx_bytes[3][i], mb);
    force_until = cyc + 20;
    send_bit(tx_bytes[3][0], mb);
    cs_end();
    check_txn("busy_stretch", rb, wb);
    if (wr_cyc_log.size() > wb + 1)
      chk("busy_defer", wr_cyc_log[wb+1] >= force_until, 1);
    else
      chk("busy_defer.present", wr_cyc_log.size() - wb, 2);

    // randomized transactions
    for (int t = 0; t < 10; t++) begin
      int a;
      int n;
      logic w;
      logic [7:0] hi;
      logic [7:0] lo;
      w = 1'($urandom_range(1, 0));
      a = (t % 3 == 0) ? $urandom_range(32767, 32764) : $urandom_range(32767, 0);
      n = $urandom_range(4, 1);
      hi = {w, 7'(a >> 8)};
      lo = 8'(a);
      tx_bytes.delete();
      tx_bytes.push_back(hi);
      tx_bytes.push_back(lo);
      for (int k = 0; k < n; k++) tx_bytes.push_back(8'($urandom));
      rb = rd_log.size(); wb = wr_a_log.size();
      run_txn();
      check_txn($sformatf("rand%0d", t), rb, wb);
    end

    // reset asserted mid-transfer (inside the read turnaround byte)
    cs_start();
    send_byte(8'h12, m);
    send_byte(8'h34, m);
    for (int i = 0; i < 3; i++) send_bit(1'b0, mb);
    #3;
    rst = 1'b1;
    #1;
    chk("reset_mid_outputs", {spi_miso, cart_wr, cart_rd, cart_dout, cart_a}, 0);
    spi_cs  = 1'b0;
    spi_sck = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rb = rd_log.size(); wb = wr_a_log.size();
    tx_bytes.delete();
    tx_bytes.push_back(8'h0A); tx_bytes.push_back(8'hBC);
    tx_bytes.push_back(8'h00); tx_bytes.push_back(8'h00);
    tx_bytes.push_back(8'h00);
    run_txn();
    check_txn("after_reset", rb, wb);

    chk("no_request_while_busy", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
